// File: rtl/gate_test_pkg.sv
// Shared types and truth-table constants for the gate sweep checker.
package gate_test_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } sweep_state_t;

   // Bit index is {in_a, in_b}.
   localparam logic [3:0] TT_AND   = 4'b1000;
   localparam logic [3:0] TT_NAND  = 4'b0111;
   localparam logic [3:0] TT_OR    = 4'b1110;
   localparam logic [3:0] TT_NOR   = 4'b0001;
   localparam logic [3:0] TT_XOR   = 4'b0110;
   localparam logic [3:0] TT_INV_A = 4'b0011;

endpackage

// File: rtl/gate_sweep_checker_settle_timer.sv
// Loadable down-counter that measures how long each vector is held.
// Loading sets SETTLE_CYCLES-1, so expire is seen on the SETTLE_CYCLES-th
// cycle after the load edge.
module settle_timer #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expire
);

   localparam int unsigned W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES - 1);

   logic [W-1:0] count_q;

   // Reload on request, otherwise count down and park at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= LOAD_VAL;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign expire = (count_q == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Clocked stimulus/response sweep for a 2-input gate: drives 00,01,10,11,
// lets each settle, samples gate_y and compares against TRUTH.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, inputs driven 00, no results
// DRIVE  | vector idx on the gate, settle timer running
// SAMPLE | one cycle: gate_y compared with TRUTH[idx] at the ending edge
// DONE   | sweep finished, inputs held 11, results valid until start
module gate_sweep_checker
   import gate_test_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [3:0]  TRUTH         = TT_AND
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       gate_y,
   output logic       in_a,
   output logic       in_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_vec,
   output logic [2:0] err_count
);

   sweep_state_t state_q, state_d;
   logic [1:0]   idx_q;
   logic [3:0]   fail_vec_q;
   logic [2:0]   err_count_q;
   logic         timer_load;
   logic         timer_expire;
   logic         accept;
   logic         sample;
   logic         mismatch;

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (timer_load),
      .expire (timer_expire)
   );

   // X or Z on the gate output must flag a mismatch, hence the case inequality.
   assign mismatch = (gate_y !== TRUTH[idx_q]);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      accept     = 1'b0;
      sample     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = DRIVE;
               timer_load = 1'b1;
               accept     = 1'b1;
            end
         end
         DRIVE: begin
            if (timer_expire) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            sample = 1'b1;
            if (idx_q == 2'd3) begin
               state_d = DONE;
            end else begin
               state_d    = DRIVE;
               timer_load = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Vector index doubles as the input drive: 00 in IDLE, idx while sweeping,
   // parked at 11 once the last vector has been sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= 2'd0;
      end else if (accept) begin
         idx_q <= 2'd0;
      end else if (sample && (idx_q != 2'd3)) begin
         idx_q <= idx_q + 2'd1;
      end
   end

   // Result accumulation; cleared on the edge that accepts a new sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_vec_q  <= 4'b0000;
         err_count_q <= 3'd0;
      end else if (accept) begin
         fail_vec_q  <= 4'b0000;
         err_count_q <= 3'd0;
      end else if (sample && mismatch) begin
         fail_vec_q[idx_q] <= 1'b1;
         err_count_q       <= err_count_q + 3'd1;
      end
   end

   assign in_a      = idx_q[1];
   assign in_b      = idx_q[0];
   assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
   assign done      = (state_q == DONE);
   assign pass      = done && (fail_vec_q == 4'b0000);
   assign fail_vec  = fail_vec_q;
   assign err_count = err_count_q;

endmodule
